i2s_tx_fifo: RTL and testbench

Parametrised Wishbone-fed I2S/left-justified stereo audio transmitter, successor to the fixed-format synth audio output.
- Samples are buffered in a FIFO and serialised onto clk_i2s / serial_data / word_select.
- Sample width, slot width, FIFO depth, clock divider and framing mode are configurable.
- Adds underrun/overflow status and a FIFO-low interrupt.
- Sits inside the user-project wrapper behind the tristate buffers, on io_out pins.

---
 rtl/i2s_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_i2s_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_fifo.sv
// Wishbone-fed stereo I2S / left-justified audio transmitter with a sample FIFO,
// sticky underrun/overflow status and a level FIFO-low interrupt.
module i2s_tx_fifo #(
   parameter int          SAMPLE_W   = 16,
   parameter int          SLOT_W     = 32,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        clk_i2s,
   output logic        serial_data,
   output logic        word_select,
   output logic        irq
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = AW + 1;
   localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_W - 1);
   localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] HALF_L   = LW'(FIFO_DEPTH / 2);

   logic          wb_req, wb_wr, addr_hit;
   logic          wr_ctrl, wr_stat, wr_data;
   logic [31:0]   rd_data;

   logic          ctrl_en, ctrl_mode;
   logic [7:0]    ctrl_div;
   logic          underrun, overflow;

   logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          fifo_empty, fifo_full, push, push_drop, pop;

   logic [7:0]    div_cnt, act_div, eff_div;
   logic          act_mode, nxt_mode;
   logic          running, chan, nxt_chan;
   logic [BW-1:0] bit_cnt, nxt_bit;
   logic [SLOT_W-1:0] shreg, slot_word;
   logic [SAMPLE_W-1:0] pop_sample;
   logic          div_tc, fall, new_slot, slot_start;
   logic          unused_dat;

   assign unused_dat = ^wbs_dat_i;

   assign addr_hit = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
   assign wb_req   = wbs_stb_i & wbs_cyc_i & addr_hit & ~wbs_ack_o;
   assign wb_wr    = wb_req & wbs_we_i & (wbs_sel_i == 4'hF);
   assign wr_ctrl  = wb_wr & (wbs_adr_i[3:0] == 4'h0);
   assign wr_stat  = wb_wr & (wbs_adr_i[3:0] == 4'h4);
   assign wr_data  = wb_wr & (wbs_adr_i[3:0] == 4'h8);

   assign fifo_empty = (level == '0);
   assign fifo_full  = (level == DEPTH_L);
   assign push       = wr_data & ~fifo_full;
   assign push_drop  = wr_data & fifo_full;
   assign pop        = slot_start & ~fifo_empty;

   // Before the first slot starts the divider follows CTRL directly, so an
   // enable write that also sets clkdiv is honoured from the very first bit.
   assign eff_div    = running ? act_div : ctrl_div;
   assign div_tc     = ctrl_en & (div_cnt >= eff_div);
   assign fall       = div_tc & clk_i2s;
   assign new_slot   = ~running | (bit_cnt == LAST_BIT);
   assign slot_start = fall & new_slot;
   assign nxt_chan   = running & (chan ^ new_slot);
   assign nxt_bit    = new_slot ? '0 : bit_cnt + BW'(1);
   assign nxt_mode   = new_slot ? ctrl_mode : act_mode;
   assign pop_sample = fifo_empty ? '0 : mem[rd_ptr];
   assign slot_word  = SLOT_W'(pop_sample) << (SLOT_W - SAMPLE_W);

   assign irq = ctrl_en & (level <= HALF_L);

   always_comb begin
      rd_data = '0;
      case (wbs_adr_i[3:0])
         4'h0:    rd_data = {16'h0, ctrl_div, 6'h0, ctrl_mode, ctrl_en};
         4'h4:    rd_data = {19'h0, overflow, underrun, fifo_full, fifo_empty, 9'(level)};
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= wb_req;
         wbs_dat_o <= (wb_req & ~wbs_we_i) ? rd_data : '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= wbs_dat_i[SAMPLE_W-1:0];
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ctrl_en   <= 1'b0;
         ctrl_mode <= 1'b0;
         ctrl_div  <= '0;
         underrun  <= 1'b0;
         overflow  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en   <= wbs_dat_i[0];
            ctrl_mode <= wbs_dat_i[1];
            ctrl_div  <= wbs_dat_i[15:8];
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
         // A new event wins over a same-cycle clear so no error is lost.
         if (slot_start && fifo_empty)      underrun <= 1'b1;
         else if (wr_stat && wbs_dat_i[11]) underrun <= 1'b0;
         if (push_drop)                     overflow <= 1'b1;
         else if (wr_stat && wbs_dat_i[12]) overflow <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         div_cnt     <= '0;
         clk_i2s     <= 1'b0;
         serial_data <= 1'b0;
         word_select <= 1'b0;
         running     <= 1'b0;
         chan        <= 1'b0;
         bit_cnt     <= '0;
         shreg       <= '0;
         act_div     <= '0;
         act_mode    <= 1'b0;
      end else if (!ctrl_en) begin
         div_cnt     <= '0;
         clk_i2s     <= 1'b0;
         serial_data <= 1'b0;
         word_select <= 1'b0;
         running     <= 1'b0;
         chan        <= 1'b0;
         bit_cnt     <= '0;
         shreg       <= '0;
         act_div     <= '0;
         act_mode    <= 1'b0;
      end else if (div_tc) begin
         div_cnt <= '0;
         clk_i2s <= ~clk_i2s;
         if (clk_i2s) begin
            running <= 1'b1;
            chan    <= nxt_chan;
            bit_cnt <= nxt_bit;
            // I2S announces the next channel on the final bit of the current slot.
            word_select <= (!nxt_mode && (nxt_bit == LAST_BIT)) ? ~nxt_chan : nxt_chan;
            if (new_slot) begin
               act_div     <= ctrl_div;
               act_mode    <= ctrl_mode;
               serial_data <= slot_word[SLOT_W-1];
               shreg       <= slot_word << 1;
            end else begin
               serial_data <= shreg[SLOT_W-1];
               shreg       <= shreg << 1;
            end
         end
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed and randomized bench for i2s_tx_fifo; the serial stream is checked
// against a queue-based model of FIFO contents and slot framing.
`timescale 1ns/1ps
module tb_i2s_tx_fifo;
   localparam int          S_W   = 16;
   localparam int          SL_W  = 32;
   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_STAT = BASE + 32'h4;
   localparam logic [31:0] A_DATA = BASE + 32'h8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_dat_i = '0;
   logic [31:0] wbs_adr_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        clk_i2s, serial_data, word_select, irq;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc_now = 0;
   logic [S_W-1:0] model_q[$];

   i2s_tx_fifo #(.SAMPLE_W(S_W), .SLOT_W(SL_W), .FIFO_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .clk_i2s(clk_i2s), .serial_data(serial_data), .word_select(word_select), .irq(irq)
   );

   always #5 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cyc_now++;

   initial begin
      #500_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic acked);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      acked = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) begin acked = 1'b1; break; end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
      wbs_sel_i = 4'hF; wbs_adr_i = adr;
      dat = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) begin dat = wbs_dat_o; break; end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_sel_i = 4'h0;
   endtask

   task automatic read_check(input logic [31:0] adr, input logic [31:0] exp, input string tag);
      logic [31:0] d;
      wb_read(adr, d);
      check(tag, d, exp);
   endtask

   task automatic push_sample(input logic [S_W-1:0] s, output logic acked);
      wb_write(A_DATA, {16'($urandom), s}, 4'hF, acked);
      if (model_q.size() < DEPTH) model_q.push_back(s);
   endtask

   task automatic wait_fall(input int limit, output bit ok);
      logic prev;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         prev = clk_i2s;
         @(posedge wb_clk_i); #1;
         if (prev && !clk_i2s) begin ok = 1'b1; break; end
      end
   endtask

   // Enable, capture nslots slots bit by bit at each falling clk_i2s, compare
   // each slot with the model, then disable.
   task automatic run_stream(input int div, input bit lj, input int nslots, input string tag);
      bit ok;
      logic acked;
      int t0, t_slot;
      logic [31:0] w, ws_w, exp_w, exp_ws;
      logic [S_W-1:0] smp;
      bit ch;
      wb_write(A_CTRL, {16'h0, 8'(div), 6'h0, lj, 1'b1}, 4'hF, acked);
      t0 = cyc_now;
      wait_fall(4 * (div + 1) + 8, ok);
      check({tag, "_first_fall_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         check({tag, "_first_fall_delay"}, cyc_now - t0, 2 * (div + 1));
         for (int k = 0; k < nslots && ok; k++) begin
            w = '0; ws_w = '0;
            t_slot = cyc_now;
            for (int b = 0; b < SL_W && ok; b++) begin
               if (b > 0) wait_fall(4 * (div + 1) + 8, ok);
               w    = {w[30:0], serial_data};
               ws_w = {ws_w[30:0], word_select};
            end
            if (!ok) begin
               check($sformatf("%s_slot%0d_bit_timeout", tag, k), 32'(ok), 32'd1);
            end else begin
               check($sformatf("%s_slot%0d_span", tag, k), cyc_now - t_slot,
                     (SL_W - 1) * 2 * (div + 1));
               ch    = k[0];
               smp   = (model_q.size() > 0) ? model_q.pop_front() : '0;
               exp_w = {smp, {(SL_W - S_W){1'b0}}};
               for (int b = 0; b < SL_W; b++)
                  exp_ws[SL_W - 1 - b] = (!lj && b == SL_W - 1) ? ~ch : ch;
               check($sformatf("%s_slot%0d_data", tag, k), w, exp_w);
               check($sformatf("%s_slot%0d_ws", tag, k), ws_w, exp_ws);
               if (k < nslots - 1) begin
                  wait_fall(4 * (div + 1) + 8, ok);
                  if (!ok) check($sformatf("%s_slot%0d_next_timeout", tag, k), 32'(ok), 32'd1);
               end
            end
         end
      end
      wb_write(A_CTRL, {16'h0, 8'(div), 6'h0, lj, 1'b0}, 4'hF, acked);
   endtask

   initial begin
      logic acked;
      bit found;
      int t0, div, n;
      bit lj;

      repeat (3) @(posedge wb_clk_i);
      #1;
      check("rst_clk_i2s", 32'(clk_i2s), 32'd0);
      check("rst_sd", 32'(serial_data), 32'd0);
      check("rst_ws", 32'(word_select), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      @(negedge wb_clk_i) wb_rst_ni = 1'b1;
      @(posedge wb_clk_i); #1;
      check("idle_ack", 32'(wbs_ack_o), 32'd0);
      check("idle_dat", wbs_dat_o, 32'd0);
      read_check(A_STAT, 32'h0000_0200, "rst_status");
      read_check(A_CTRL, 32'h0, "rst_ctrl");
      read_check(A_DATA, 32'h0, "data_reads_zero");

      // register access boundaries
      wb_write(32'h4000_0000, 32'h1, 4'hF, acked);
      check("unmatched_no_ack", 32'(acked), 32'd0);
      wb_write(A_CTRL, 32'h0000_0F03, 4'h3, acked);
      check("partial_sel_ack", 32'(acked), 32'd1);
      read_check(A_CTRL, 32'h0, "partial_sel_ignored");
      wb_write(A_CTRL, 32'hFFFF_AB02, 4'hF, acked);
      read_check(A_CTRL, 32'h0000_AB02, "ctrl_readback");
      wb_write(A_CTRL, 32'h0, 4'hF, acked);

      // I2S, clkdiv 0
      push_sample(16'h1234, acked);
      push_sample(16'hABCD, acked);
      check("irq_off_while_disabled", 32'(irq), 32'd0);
      read_check(A_STAT, 32'h0000_0002, "status_level2");
      run_stream(0, 1'b0, 2, "i2s_div0");
      read_check(A_STAT, 32'h0000_0200, "i2s_div0_status");

      // left-justified, clkdiv 3
      push_sample(16'h1234, acked);
      push_sample(16'hABCD, acked);
      run_stream(3, 1'b1, 2, "lj_div3");
      read_check(A_STAT, 32'h0000_0200, "lj_div3_status");

      // empty FIFO: zeros and sticky underrun
      run_stream(1, 1'b0, 2, "empty");
      read_check(A_STAT, 32'h0000_0A00, "underrun_set");
      wb_write(A_STAT, 32'h0000_0800, 4'hF, acked);
      read_check(A_STAT, 32'h0000_0200, "underrun_cleared");

      // overflow and irq threshold
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_sample(16'($urandom), acked);
         check($sformatf("ovf_push%0d_ack", i), 32'(acked), 32'd1);
      end
      read_check(A_STAT, 32'h0000_1408, "ovf_status");
      check("ovf_irq_disabled", 32'(irq), 32'd0);
      wb_write(A_CTRL, 32'h0000_0001, 4'hF, acked);
      t0 = cyc_now;
      check("irq_level8", 32'(irq), 32'd0);
      // pops land at t0+2+64k
      while (cyc_now < t0 + 140) begin @(posedge wb_clk_i); #1; end
      check("irq_level5", 32'(irq), 32'd0);
      while (cyc_now < t0 + 204) begin @(posedge wb_clk_i); #1; end
      check("irq_level4", 32'(irq), 32'd1);
      read_check(A_STAT, 32'h0000_1004, "status_level4");
      wb_write(A_CTRL, 32'h0, 4'hF, acked);
      check("irq_after_disable", 32'(irq), 32'd0);
      repeat (4) void'(model_q.pop_front());
      wb_write(A_STAT, 32'h0000_1000, 4'hF, acked);
      read_check(A_STAT, 32'h0000_0004, "overflow_cleared");
      run_stream(0, 1'b1, 4, "drain");
      read_check(A_STAT, 32'h0000_0200, "drain_status");

      // randomized rounds
      for (int r = 0; r < 3; r++) begin
         div = $urandom_range(0, 3);
         lj  = 1'($urandom_range(0, 1));
         n   = 2 * $urandom_range(1, 4);
         for (int i = 0; i < n; i++) push_sample(16'($urandom), acked);
         run_stream(div, lj, n, $sformatf("rnd%0d", r));
         read_check(A_STAT, 32'h0000_0200, $sformatf("rnd%0d_status", r));
      end

      // asynchronous reset in the right slot, during an ack
      push_sample(16'h5A5A, acked);
      push_sample(16'hC3C3, acked);
      wb_write(A_CTRL, 32'h0000_0003, 4'hF, acked);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge wb_clk_i); #1;
         if (word_select) begin found = 1'b1; break; end
      end
      check("rst_reach_right_slot", 32'(found), 32'd1);
      repeat (5) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_STAT; wbs_sel_i = 4'hF;
      @(posedge wb_clk_i); #2;
      wb_rst_ni = 1'b0;
      #1;
      check("midrst_clk_i2s", 32'(clk_i2s), 32'd0);
      check("midrst_sd", 32'(serial_data), 32'd0);
      check("midrst_ws", 32'(word_select), 32'd0);
      check("midrst_ack", 32'(wbs_ack_o), 32'd0);
      check("midrst_dat", wbs_dat_o, 32'd0);
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_sel_i = 4'h0;
      model_q.delete();
      @(negedge wb_clk_i) wb_rst_ni = 1'b1;
      read_check(A_STAT, 32'h0000_0200, "midrst_status");
      read_check(A_CTRL, 32'h0, "midrst_ctrl");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
